// File: rtl/round_robin_fifo_distributor_pkg.sv
// rtl/round_robin_fifo_distributor_pkg.sv - shared widths and channel encodings for the distributor
package round_robin_fifo_distributor_pkg;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int NCH   = 4;
  localparam int PTRW  = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    CH_A = 2'd0,
    CH_B = 2'd1,
    CH_C = 2'd2,
    CH_D = 2'd3
  } ch_e;
endpackage

// File: rtl/round_robin_fifo_distributor_sync_fifo_d8.sv
// rtl/round_robin_fifo_distributor_sync_fifo_d8.sv - one channel FIFO with registered read port
module sync_fifo_d8
  import round_robin_fifo_distributor_pkg::*;
#(
  parameter int W = DW,
  parameter int D = DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         rvalid,
  output logic         rerr,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(D);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic          rvalid_q, rerr_q;
  logic          do_wr, do_rd;

  assign full  = (count_q == CW'(D));
  assign empty = (count_q == '0);
  // Flags are pre-edge: a read on a full FIFO does not make room for a same-edge write.
  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;

  always_comb begin
    wptr_d  = do_wr ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = do_rd ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    if (do_wr && !do_rd) count_d = count_q + CW'(1);
    if (do_rd && !do_wr) count_d = count_q - CW'(1);
    rdata_d = do_rd ? mem[rptr_q] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= do_rd;
      rerr_q   <= rd & empty;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr_q] <= wdata;
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign rerr   = rerr_q;
endmodule

// File: rtl/round_robin_fifo_distributor.sv
// rtl/round_robin_fifo_distributor.sv - deals one write stream to four channel FIFOs in strict rotation
module round_robin_fifo_distributor
  import round_robin_fifo_distributor_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic [DW-1:0]     din,
  output logic              ready,
  output logic [1:0]        sel,
  output logic              wr_error,
  input  logic [NCH-1:0]    ren,
  output logic [NCH*DW-1:0] dout,
  output logic [NCH-1:0]    valid,
  output logic [NCH-1:0]    rd_error,
  output logic [NCH-1:0]    empty,
  output logic [NCH-1:0]    full
);
  logic [1:0] sel_q, sel_d;
  logic       wr_error_q, wr_error_d;
  logic       accept;

  // sel never skips a full channel, so a stall keeps the rotation order intact.
  assign ready  = ~full[sel_q];
  assign accept = wen & ready;

  always_comb begin
    sel_d      = accept ? sel_q + 2'd1 : sel_q;
    wr_error_d = wen & ~accept;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q      <= CH_A;
      wr_error_q <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      wr_error_q <= wr_error_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    sync_fifo_d8 #(.W(DW), .D(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (accept && (sel_q == 2'(i))),
      .wdata (din),
      .rd    (ren[i]),
      .rdata (dout[i*DW +: DW]),
      .rvalid(valid[i]),
      .rerr  (rd_error[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  assign sel      = sel_q;
  assign wr_error = wr_error_q;
endmodule

// File: tb/tb_round_robin_fifo_distributor.sv
// tb/tb_round_robin_fifo_distributor.sv - queue-model checked directed bench for the distributor
module tb_round_robin_fifo_distributor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wen = 1'b0;
  logic [7:0]  din = '0;
  logic [3:0]  ren = '0;
  logic        ready, wr_error;
  logic [1:0]  sel;
  logic [31:0] dout;
  logic [3:0]  valid, rd_error, empty, full;

  round_robin_fifo_distributor dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .din(din), .ready(ready), .sel(sel),
    .wr_error(wr_error), .ren(ren), .dout(dout), .valid(valid), .rd_error(rd_error),
    .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [7:0]  mq [4][$];
  int          m_sel = 0;
  logic [31:0] m_dout = '0;
  logic [3:0]  m_valid = '0, m_rderr = '0;
  logic        m_werr = 1'b0;

  task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pf [4];
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      m_sel = 0; m_dout = '0; m_valid = '0; m_rderr = '0; m_werr = 1'b0;
      return;
    end
    for (int i = 0; i < 4; i++) pf[i] = (mq[i].size() == 8);
    for (int i = 0; i < 4; i++) begin
      m_dout[i*8 +: 8] = 8'h00; m_valid[i] = 1'b0; m_rderr[i] = 1'b0;
      if (ren[i]) begin
        if (mq[i].size() > 0) begin
          m_dout[i*8 +: 8] = mq[i].pop_front();
          m_valid[i] = 1'b1;
        end else m_rderr[i] = 1'b1;
      end
    end
    if (wen) begin
      if (pf[m_sel]) m_werr = 1'b1;
      else begin
        mq[m_sel].push_back(din);
        m_sel = (m_sel + 1) % 4;
        m_werr = 1'b0;
      end
    end else m_werr = 1'b0;
  endtask

  // Every cycle: all DUT outputs against the queue model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] e_empty, e_full;
      for (int i = 0; i < 4; i++) begin
        e_empty[i] = (mq[i].size() == 0);
        e_full[i]  = (mq[i].size() == 8);
      end
      expect_val("sel", 32'(sel), 32'(m_sel));
      expect_val("wr_error", 32'(wr_error), 32'(m_werr));
      expect_val("dout", dout, m_dout);
      expect_val("valid", 32'(valid), 32'(m_valid));
      expect_val("rd_error", 32'(rd_error), 32'(m_rderr));
      expect_val("empty", 32'(empty), 32'(e_empty));
      expect_val("full", 32'(full), 32'(e_full));
      expect_val("ready", 32'(ready), 32'(!e_full[m_sel]));
    end
  end

  task automatic cyc(input logic w, input logic [7:0] d, input logic [3:0] r, input logic rn);
    @(negedge clk);
    wen = w; din = d; ren = r; rst_n = rn;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 4'b0000, 1'b1);
  endtask

  task automatic do_reset();
    cyc(1'b0, 8'h00, 4'b0000, 1'b0);
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    do_reset();
    expect_val("rst_sel", 32'(sel), 32'd0);
    expect_val("rst_empty", 32'(empty), 32'hF);
    expect_val("rst_dout", dout, 32'h0);

    // Eight writes, then two full-width reads.
    for (int k = 0; k < 8; k++) cyc(1'b1, 8'h10 + 8'(k), 4'b0000, 1'b1);
    expect_val("t1_sel_wrap", 32'(sel), 32'd0);
    cyc(1'b0, 8'h00, 4'b1111, 1'b1);
    expect_val("t1_rd1_dout", dout, 32'h13121110);
    expect_val("t1_rd1_valid", 32'(valid), 32'hF);
    cyc(1'b0, 8'h00, 4'b1111, 1'b1);
    expect_val("t1_rd2_dout", dout, 32'h17161514);
    idle();

    // Fill all channels, reject the 33rd, free one slot in A and retry.
    for (int k = 0; k < 32; k++) cyc(1'b1, 8'(k), 4'b0000, 1'b1);
    expect_val("t2_full", 32'(full), 32'hF);
    expect_val("t2_ready", 32'(ready), 32'd0);
    cyc(1'b1, 8'hFF, 4'b0000, 1'b1);
    expect_val("t2_wr_error", 32'(wr_error), 32'd1);
    expect_val("t2_sel_hold", 32'(sel), 32'd0);
    cyc(1'b0, 8'h00, 4'b0001, 1'b1);
    expect_val("t2_readA", 32'(dout[7:0]), 32'h00);
    cyc(1'b1, 8'hFF, 4'b0000, 1'b1);
    expect_val("t2_retry_err", 32'(wr_error), 32'd0);
    expect_val("t2_retry_sel", 32'(sel), 32'd1);
    for (int k = 0; k < 8; k++) cyc(1'b0, 8'h00, 4'b1111, 1'b1);
    expect_val("t2_drain_last_A", 32'(dout[7:0]), 32'hFF);

    // Full A: same-edge read and write, write rejected on pre-edge flag.
    do_reset();
    for (int k = 0; k < 32; k++) cyc(1'b1, 8'(k), 4'b0000, 1'b1);
    cyc(1'b1, 8'hEE, 4'b0001, 1'b1);
    expect_val("t3_dout", 32'(dout[7:0]), 32'h00);
    expect_val("t3_valid0", 32'(valid[0]), 32'd1);
    expect_val("t3_wr_error", 32'(wr_error), 32'd1);
    expect_val("t3_fullA", 32'(full[0]), 32'd0);

    // Read of empty channel C.
    do_reset();
    cyc(1'b0, 8'h00, 4'b0100, 1'b1);
    expect_val("t4_rd_error", 32'(rd_error), 32'h4);
    expect_val("t4_valid2", 32'(valid[2]), 32'd0);
    expect_val("t4_dout2", 32'(dout[23:16]), 32'h00);
    idle();
    expect_val("t4_rd_error_clr", 32'(rd_error), 32'h0);

    // B holds 3, simultaneous read and write of AB.
    do_reset();
    for (int k = 0; k < 13; k++) cyc(1'b1, 8'h20 + 8'(k), 4'b0000, 1'b1);
    cyc(1'b1, 8'hAB, 4'b0010, 1'b1);
    expect_val("t5_rd", 32'(dout[15:8]), 32'h21);
    cyc(1'b0, 8'h00, 4'b0010, 1'b1);
    expect_val("t5_d1", 32'(dout[15:8]), 32'h25);
    cyc(1'b0, 8'h00, 4'b0010, 1'b1);
    expect_val("t5_d2", 32'(dout[15:8]), 32'h29);
    cyc(1'b0, 8'h00, 4'b0010, 1'b1);
    expect_val("t5_d3", 32'(dout[15:8]), 32'hAB);
    expect_val("t5_emptyB", 32'(empty[1]), 32'd1);

    // Mid-stream reset with wen and ren active.
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'h40 + 8'(k), 4'b0000, 1'b1);
    cyc(1'b1, 8'h55, 4'b1111, 1'b0);
    expect_val("t6_empty", 32'(empty), 32'hF);
    expect_val("t6_sel", 32'(sel), 32'd0);
    expect_val("t6_outs", {dout[31:4] | dout[3:0], valid | rd_error}, 32'h0);
    expect_val("t6_wr_error", 32'(wr_error), 32'd0);
    idle();
    idle();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/round_robin_fifo_distributor.md
Name: round_robin_fifo_distributor

Overview:
- Inverse of the round-robin FIFO arbiter: takes one 8-bit write stream and deals accepted words to four 8-deep channel FIFOs (A, B, C, D) in strict rotation.
- Each channel is drained independently by its own consumer through a per-channel read strobe, registered data and valid flag.
- Sits at the fan-out end of the stream: arbiter output, or any single producer, feeds this block's write port.

Parameters:
- DW, 8, data width of every word.
- DEPTH, 8, entries per channel FIFO; power of two, ≥2.
- NCH, 4, number of channels; fixed at 4, with a 2-bit selector.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- wen  in  1  write strobe for din.
- din  in  DW  write data.
- ready  out  1  combinational; 1 when the channel at sel is not full.
- sel  out  2  registered; channel that receives the next accepted write.
- wr_error  out  1  registered; 1 for one cycle after a rejected write.
- ren  in  NCH  per-channel read strobe; bit i reads channel i.
- dout  out  NCH*DW  registered; channel i occupies bits [i*DW +: DW].
- valid  out  NCH  registered; bit i=1 when dout slice i holds a word read last cycle.
- rd_error  out  NCH  registered; bit i=1 for one cycle after a read of empty channel i.
- empty  out  NCH  combinational per-channel empty flags.
- full  out  NCH  combinational per-channel full flags.

Behaviour:
- Reset, sampled on posedge with rst_n=0:
  - All FIFOs empty, pointers 0, sel=0.
  - dout=0, valid=0, rd_error=0, wr_error=0.
  - Reset mid-operation discards all stored data. Whatever is on wen/ren that cycle is ignored.
- Write path:
  - Write accepted when wen=1 and full[sel]=0 at the sampling edge.
  - On accept: the word is stored in FIFO[sel], sel <= sel+1 (mod 4, 3 wraps to 0), wr_error <= 0.
  - On reject (wen=1, full[sel]=1): word dropped, sel holds, wr_error <= 1. sel never skips a full channel, so rotation order is preserved.
  - wen=0: sel holds, wr_error <= 0.
- Read path, each channel independent:
  - ren[i]=1 and channel non-empty: the oldest word goes to dout slice i next cycle with valid[i]=1, rd_error[i]=0. Latency 1 cycle.
  - ren[i]=1 and channel empty: dout slice i <= 0, valid[i] <= 0, rd_error[i] <= 1.
  - ren[i]=0: dout slice i <= 0, valid[i] <= 0, rd_error[i] <= 0.
- Simultaneous read and write on the same channel:
  - Non-empty and not full: both happen; occupancy unchanged.
  - Full: the write is rejected using the pre-edge full flag, even though the read frees a slot the same edge; the read still succeeds.
  - Empty: the read errors and the write is accepted; no bypass, so the word is readable from the next cycle.
- Occupancy and flags:
  - Occupancy is tracked with a (log2(DEPTH)+1)-bit count or with extra-bit pointers; all DEPTH entries are usable.
  - Pointers wrap modulo DEPTH.
  - full = (count==DEPTH); empty = (count==0).
- Ordering: per-channel FIFO order. Global word k (counting accepted writes only) lands in channel k mod 4.

Decomposition:
- Shared package: DW, DEPTH, NCH defaults, the channel index encodings CH_A=0..CH_D=3, and the pointer/count width derived as clog2(DEPTH)+1.
- One sub-module, instantiated 4×: sync_fifo_d8.
  - Ports: clk, rst_n, wr, wdata, rd, rdata (registered, 0 when not read), rvalid, rerr, full, empty.
  - The top level holds only the sel counter, write steering, wr_error and output packing.

Test Plan:
- Reset, then write 8'h10, 11, 12, 13, 14, 15, 16, 17 with no reads → sel returns to 0. Channels hold A:{10,14} B:{11,15} C:{12,16} D:{13,17}. Then ren=4'b1111 for two cycles → cycle 1 dout={13,12,11,10} (D..A) with valid=4'b1111; cycle 2 dout={17,16,15,14}.
- Write 32 words 8'h00..8'h1F → all full=1, ready=0. The 33rd write (8'hFF) → wr_error=1 next cycle, sel stays 0. Then read A once and retry 8'hFF → accepted into A, sel=1.
- Channel A full, ren[0]=1 and wen=1 with sel=0 on the same edge → read returns 8'h00 with valid[0]=1. Write rejected, wr_error=1, A count drops to 7.
- Read of empty channel C: ren=4'b0100 → rd_error=4'b0100, valid[2]=0, dout slice 2=0. The next cycle with ren=0 → rd_error=0.
- Channel B holding 3 words, simultaneous ren[1]=1 and a write of 8'hAB to B → count stays 3, and 8'hAB is the last of the three words drained afterwards.
- Mid-stream rst_n=0 for one cycle with 5 words stored and wen=1 → afterwards empty=4'b1111, sel=0, and all outputs are 0.
